tx_frame_sender: RTL

TX_FRAME_SENDER -- requirements
Module: tx_frame_sender

---
 rtl/tx_frame_if.sv | 20 ++
 rtl/tx_frame_sender.sv | 108 ++++++++++
 2 files changed

// File: rtl/tx_frame_if.sv
// Handshake bundle between a frame requester, tx_frame_sender and the byte transmitter.
interface tx_frame_if;
    logic        Frame_Start;
    logic [55:0] Frame_Data;
    logic        TX_Done_Sig;
    logic        TX_En_Sig;
    logic [7:0]  TX_Data;
    logic        Busy;
    logic        Frame_Done_Sig;

    modport master (
        output Frame_Start, Frame_Data, TX_Done_Sig,
        input  TX_En_Sig, TX_Data, Busy, Frame_Done_Sig
    );

    modport slave (
        input  Frame_Start, Frame_Data, TX_Done_Sig,
        output TX_En_Sig, TX_Data, Busy, Frame_Done_Sig
    );
endinterface

// File: rtl/tx_frame_sender.sv
// Serialises a 7-byte frame (MSB byte first) into a byte transmitter, with one idle
// cycle between bytes and a programmable gap before the single-cycle completion pulse.
module tx_frame_sender #(
    parameter int GAP_CYCLES = 16
) (
    input logic      CLK,
    input logic      RSTn,
    tx_frame_if.slave bus
);
    localparam logic [2:0]  LAST_IDX = 3'd6;
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND, SPACE, GAP, DONE} state_t;

    state_t      state, state_nxt;
    logic [55:0] shift_q, shift_nxt;
    logic [2:0]  idx_q, idx_nxt;
    logic [15:0] gap_q, gap_nxt;
    logic        tx_en_q, tx_en_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            tx_en_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            idx_q   <= idx_nxt;
            gap_q   <= gap_nxt;
            tx_en_q <= tx_en_nxt;
            data_q  <= data_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.Frame_Start) state_nxt = SEND;
            SEND: begin
                if (bus.TX_Done_Sig) begin
                    if (idx_q != LAST_IDX)    state_nxt = SPACE;
                    else if (GAP_CYCLES == 0) state_nxt = DONE;
                    else                      state_nxt = GAP;
                end
            end
            SPACE: state_nxt = SEND;
            GAP:   if (gap_q == GAP_LAST) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The top byte of the shift register is always the next byte to offer
    always_comb begin
        shift_nxt = shift_q;
        idx_nxt   = idx_q;
        gap_nxt   = gap_q;
        tx_en_nxt = tx_en_q;
        data_nxt  = data_q;
        busy_nxt  = busy_q;
        done_nxt  = (state_nxt == DONE);
        case (state)
            IDLE: begin
                if (bus.Frame_Start) begin
                    shift_nxt = bus.Frame_Data;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    tx_en_nxt = 1'b1;
                    data_nxt  = bus.Frame_Data[55:48];
                end
            end
            SEND: begin
                if (bus.TX_Done_Sig) begin
                    tx_en_nxt = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        shift_nxt = {shift_q[47:0], 8'h00};
                        idx_nxt   = idx_q + 3'd1;
                    end else begin
                        gap_nxt = '0;
                    end
                end
            end
            SPACE: begin
                tx_en_nxt = 1'b1;
                data_nxt  = shift_q[55:48];
            end
            GAP:  gap_nxt = gap_q + 16'd1;
            DONE: busy_nxt = 1'b0;
            default: ;
        endcase
    end

    assign bus.TX_En_Sig      = tx_en_q;
    assign bus.TX_Data        = data_q;
    assign bus.Busy           = busy_q;
    assign bus.Frame_Done_Sig = done_q;
endmodule
